// File: rtl/shift_normalizer_if.sv
// shift_normalizer_if: operand/result handshake bundle for the normalizer.
// master drives operands and consumes results; slave is the normalizer.
interface shift_normalizer_if #(
    parameter int WIDTH = 8,
    parameter int SH_W  = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic [SH_W-1:0]  shift_out;
    logic             zero;

    modport master (
        output in_valid, data_in, mode, out_ready,
        input  in_ready, out_valid, data_out, shift_out, zero
    );

    modport slave (
        input  in_valid, data_in, mode, out_ready,
        output in_ready, out_valid, data_out, shift_out, zero
    );
endinterface

// File: rtl/shift_normalizer.sv
// shift_normalizer: sequential left-normalizer (clz / redundant sign bits).
// Optional macro SHNORM_SKIP2_EN enables a two-bit unsigned fast path.
module shift_normalizer #(
    parameter int WIDTH = 8,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    shift_normalizer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             mode_q, mode_d;
    logic [SH_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic             zero_q, zero_d;

    logic is_zero;
    logic at_cap;
    logic normed;
    logic stop;
    logic skip2;

    assign is_zero = (work_q == '0);
    assign at_cap  = (cnt_q == SH_W'(WIDTH - 1));
    assign normed  = mode_q ? (work_q[WIDTH-1] ^ work_q[WIDTH-2])
                            : work_q[WIDTH-1];
    assign stop    = is_zero | normed | at_cap;

`ifdef SHNORM_SKIP2_EN
    // Unsigned only: two leading zeros and room for two more shifts.
    assign skip2 = !mode_q
                 && (work_q[WIDTH-1 -: 2] == 2'b00)
                 && !is_zero
                 && (cnt_q <= SH_W'(WIDTH - 3));
`else
    assign skip2 = 1'b0;
`endif

    // State and datapath registers; reset drops any in-flight operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            dout_q  <= '0;
            sh_q    <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            sh_q    <= sh_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) state_d = BUSY;
            BUSY: if (stop) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load, shift until normalized, then capture result.
    always_comb begin
        work_d = work_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        sh_d   = sh_q;
        zero_d = zero_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d = bus.data_in;
                    mode_d = bus.mode;
                    cnt_d  = '0;
                end
            end
            BUSY: begin
                if (is_zero) begin
                    zero_d = 1'b1;
                    dout_d = '0;
                    sh_d   = '0;
                end else if (stop) begin
                    zero_d = 1'b0;
                    dout_d = work_q;
                    sh_d   = cnt_q;
                end else if (skip2) begin
                    work_d = work_q << 2;
                    cnt_d  = cnt_q + SH_W'(2);
                end else begin
                    work_d = work_q << 1;
                    cnt_d  = cnt_q + SH_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs: handshake flags follow state, result comes from registers.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.data_out  = dout_q;
        bus.shift_out = sh_q;
        bus.zero      = zero_q;
    end

endmodule
